// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the sequential restoring divider:
//   WIDTH_DEF  - default operand/result width
//   state_e    - controller state encoding (IDLE / RUN / DONE)
//   cnt_width  - width of the iteration counter for a given operand width
//   CNT_W      - iteration counter width for the default operand width
// -----------------------------------------------------------------------------
package seq_div_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter runs from WIDTH-1 down to 0; at least one bit is always kept.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/csub17.sv
// -----------------------------------------------------------------------------
// csub17
// Purely combinational N-bit subtractor (default N = 17), diff = a + ~b + 1.
// Carries are resolved inside 4-bit blocks by generate/propagate lookahead.
// Each block hands its group carry to the next block.
//   a_i        - minuend
//   b_i        - subtrahend
//   diff_o     - a_i - b_i modulo 2**N
//   borrow_out - 1 when a_i < b_i (no carry out of the top bit)
// -----------------------------------------------------------------------------
module csub17 #(
  parameter int N = 17
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_out
);

  logic [N-1:0] prop_s;
  logic [N-1:0] gen_s;
  logic [N:0]   carry_s;   // carry_s[i] is the carry into bit i
  logic         grp_cin_s; // carry into the current 4-bit block
  logic         grp_g_s;   // running block generate, from block LSB up to bit i
  logic         grp_p_s;   // running block propagate, from block LSB up to bit i

  // Block lookahead: within a block, the carry into bit i+1 is built from
  // the prefix generate/propagate terms and the block carry-in. Between
  // blocks, the carry ripples at block granularity. A short top block
  // (N not a multiple of 4) simply closes early.
  always_comb begin
    prop_s     = a_i ^ ~b_i;
    gen_s      = a_i & ~b_i;
    carry_s    = '0;
    carry_s[0] = 1'b1;
    grp_cin_s  = 1'b1;
    grp_g_s    = 1'b0;
    grp_p_s    = 1'b1;
    for (int i = 0; i < N; i++) begin
      if ((i % 4) == 0) begin
        grp_g_s = 1'b0;
        grp_p_s = 1'b1;
      end else begin
        grp_g_s = grp_g_s;
      end
      grp_g_s        = gen_s[i] | (prop_s[i] & grp_g_s);
      grp_p_s        = grp_p_s & prop_s[i];
      carry_s[i + 1] = grp_g_s | (grp_p_s & grp_cin_s);
      if (((i % 4) == 3) || (i == N - 1)) begin
        grp_cin_s = carry_s[i + 1];
      end else begin
        grp_cin_s = grp_cin_s;
      end
    end
    diff_o     = prop_s ^ carry_s[N-1:0];
    borrow_out = ~carry_s[N];
  end

endmodule

// File: rtl/seq_div16.sv
// -----------------------------------------------------------------------------
// seq_div16
// Sequential unsigned restoring divider. It produces one quotient bit per
// cycle, MSB first, and uses valid/ready handshakes on both sides.
//   clk, rst          - clock and synchronous active-high reset
//   in_valid/in_ready - operand handshake (dividend, divisor)
//   out_valid/out_ready - result handshake (quotient, remainder, div_by_zero)
// A zero divisor produces quotient = all ones, remainder = dividend and
// div_by_zero = 1, one edge after acceptance.
// -----------------------------------------------------------------------------
module seq_div16
  import seq_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits still to shift in, quotient bits shifted in behind them
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   r_q, r_d;       // partial remainder R
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d; // the latched divisor was zero
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shift_r;        // {R[WIDTH-1:0], next dividend bit}
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_r_msb;

  // The restoring algorithm keeps R below the divisor, so R[WIDTH] is never
  // set and the shift drops it.
  assign unused_r_msb = r_q[WIDTH];

  assign shift_r = {r_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  csub17 #(
    .N (WIDTH + 1)
  ) u_csub (
    .a_i        (shift_r),
    .b_i        ({1'b0, dvs_q}),
    .diff_o     (trial_diff),
    .borrow_out (trial_borrow)
  );

  // A borrow restores the shifted remainder; otherwise the difference is kept.
  assign r_next = trial_borrow ? shift_r : trial_diff;
  assign q_next = {dvd_q[WIDTH-2:0], ~trial_borrow};

  // Next-state and datapath control for IDLE / RUN / DONE.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          r_d     = '0;
          cnt_d   = CW'(WIDTH - 1);
          zero_d  = (divisor == '0);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (zero_q) begin
          // A zero divisor spends a single RUN cycle, then reports.
          quo_d   = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          r_d   = r_next;
          dvd_d = q_next;
          if (cnt_q == '0) begin
            quo_d   = q_next;
            rem_d   = r_next[WIDTH-1:0];
            dbz_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div16.sv
// -----------------------------------------------------------------------------
// tb_seq_div16
// Self-checking bench for seq_div16. Expected results are pushed onto a
// scoreboard queue when operands are accepted. They are popped and compared
// when the result handshake is offered.
// -----------------------------------------------------------------------------
module tb_seq_div16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  seq_div16 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present operands for one accepting edge, and record the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    sb.push_back(model(a, b));
    if (hold) begin
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Count edges after acceptance until out_valid; garbage operands stay offered when hold=1.
  task automatic wait_result(input bit hold, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (hold) begin
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
        remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0000 0000 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    issue(16'd100, 16'd7, 1'b0);
    wait_result(1'b0, lat);
    total++;
    if (lat !== 16) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=16", lat);
    end
    e = sb.pop_front();
    total++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0 ||
        quotient !== e.q || remainder !== e.r) begin
      bad++;
      $display("FAIL basic_result got q=%0d r=%0d z=%b want q=14 r=2 z=0",
               quotient, remainder, div_by_zero);
    end
    handshake();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_handshake got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] ta[4];
    logic [W-1:0] tb[4];
    int           tl[4];
    int           lat;
    exp_t         e;
    ta = '{16'hFFFF, 16'hFFFF, 16'd3,  16'd5};
    tb = '{16'h0001, 16'hFFFF, 16'd10, 16'd0};
    tl = '{16, 16, 16, 1};
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], 1'b0);
      wait_result(1'b0, lat);
      e = sb.pop_front();
      total++;
      if (lat !== tl[i]) begin
        bad++;
        $display("FAIL corner%0d_latency got=%0d want=%0d", i, lat, tl[i]);
      end
      total++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
        bad++;
        $display("FAIL corner%0d_result got q=%h r=%h z=%b want q=%h r=%h z=%b",
                 i, quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int           lat;
    int           unstable = 0;
    logic [W-1:0] q0;
    logic [W-1:0] r0;
    exp_t         e;
    issue(16'd1234, 16'd56, 1'b0);
    wait_result(1'b0, lat);
    e  = sb.pop_front();
    q0 = quotient;
    r0 = remainder;
    total++;
    if (q0 !== e.q || r0 !== e.r) begin
      bad++;
      $display("FAIL bp_result got q=%0d r=%0d want q=%0d r=%0d", q0, r0, e.q, e.r);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || quotient !== q0 || remainder !== r0 || div_by_zero !== 1'b0) begin
        unstable++;
      end
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL bp_stable got unstable_cycles=%0d want 0", unstable);
    end
    handshake();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== e.q || remainder !== e.r) begin
      bad++;
      $display("FAIL bp_release got vld=%b rdy=%b q=%0d r=%0d want 0 1 %0d %0d",
               out_valid, in_ready, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset_abort();
    int   lat;
    int   pulses = 0;
    exp_t e;
    issue(16'd50000, 16'd3, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0) begin
      bad++;
      $display("FAIL abort_state got rdy=%b vld=%b q=%0d r=%0d want 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) begin
        pulses++;
      end
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL abort_no_result got valid_cycles=%0d want 0", pulses);
    end
    issue(16'd1000, 16'd9, 1'b0);
    wait_result(1'b0, lat);
    e = sb.pop_front();
    total++;
    if (lat !== 16 || quotient !== 16'd111 || remainder !== 16'd1 || quotient !== e.q) begin
      bad++;
      $display("FAIL abort_next got lat=%0d q=%0d r=%0d want 16 111 1", lat, quotient, remainder);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int           lat;
    int           sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    longint       recon;
    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 15);
      a   = (sel < 4) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      if (sel == 0) begin
        b = 16'd0;
      end else if (sel < 6) begin
        b = 16'($urandom_range(1, 15));
      end else begin
        b = 16'($urandom);
      end
      issue(a, b, 1'b1);
      wait_result(1'b1, lat);
      e = sb.pop_front();
      total++;
      if (lat !== ((b == 16'd0) ? 1 : 16)) begin
        bad++;
        $display("FAIL rand%0d_latency a=%0d b=%0d got=%0d", n, a, b, lat);
      end
      total++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
        bad++;
        $display("FAIL rand%0d_result a=%0d b=%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                 n, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
      if (b != 16'd0) begin
        recon = longint'(quotient) * longint'(b) + longint'(remainder);
        total++;
        if (recon !== longint'(a) || remainder >= b) begin
          bad++;
          $display("FAIL rand%0d_invariant a=%0d b=%0d got q=%0d r=%0d", n, a, b, quotient, remainder);
        end
      end
      handshake();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d_release got vld=%b rdy=%b want 0 1", n, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = 16'd0;
    divisor   = 16'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
